// File: rtl/x2c_pkg.sv
// x2c_pkg: shared definitions for the x2c control/data FIFO consumer.
//   - control word field positions (length, error flag)
//   - sequencer FSM state encoding
//   - be_last(): byte enables of the final beat of a packet
package x2c_pkg;

   localparam int LEN_LSB = 0;
   localparam int LEN_MSB = 15;
   localparam int ERR_BIT = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CWAIT = 2'd1,
      DATA  = 2'd2
   } state_t;

   // A length that is a multiple of 8 fills the last beat completely.
   function automatic logic [7:0] be_last(input logic [2:0] len_lo);
      be_last = (len_lo == 3'd0) ? 8'hFF : 8'((8'd1 << len_lo) - 8'd1);
   endfunction

endpackage

// File: rtl/x2c_skid_buf2.sv
// x2c_skid_buf2: two-entry valid/ready buffer with registered head outputs.
// The upstream side has no ready; the producer limits itself using occ.
// Ports:
//   clk, srst            clock, synchronous active-high reset
//   in_valid, in_data    beat written this cycle (must not arrive when full)
//   out_valid, out_data  registered buffer head
//   out_ready            head consumed when out_valid & out_ready
//   occ                  entries held (0..2)
module x2c_skid_buf2 #(
   parameter int W = 75
) (
   input  logic         clk,
   input  logic         srst,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic [1:0]   occ
);

   logic         tail_vld;
   logic [W-1:0] tail_data;
   logic         head_free;

   assign head_free = !out_valid || out_ready;
   assign occ       = {1'b0, out_valid} + {1'b0, tail_vld};

   always_ff @(posedge clk) begin
      if (srst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         tail_vld  <= 1'b0;
      end else if (head_free) begin
         if (tail_vld) begin
            out_valid <= 1'b1;
            out_data  <= tail_data;
            tail_vld  <= in_valid;
         end else begin
            out_valid <= in_valid;
            if (in_valid) out_data <= in_data;
         end
      end else if (in_valid) begin
         tail_vld <= 1'b1;
      end
   end

   // Tail payload needs no reset: it is only observed behind tail_vld.
   always_ff @(posedge clk) begin
      if (in_valid && (!head_free || tail_vld)) tail_data <= in_data;
   end

endmodule

// File: rtl/x2c_ctrl_pkt_sequencer.sv
// x2c_ctrl_pkt_sequencer: consumer of the x2c control FIFO and its data FIFO.
// Pops one control word per packet, then that packet's data words, and
// presents them as a valid/ready beat stream with sop/eop/byte enables.
// Ports:
//   clk, srst                        clock, synchronous active-high reset
//   ctrl_rdreq/ctrl_q/ctrl_empty     control FIFO (non-FWFT, q one cycle after rdreq)
//   data_rdreq/data_q/data_empty     data FIFO (non-FWFT)
//   out_valid/out_ready/out_data     beat stream toward the core
//   out_sop/out_eop/out_be/out_err   beat framing; out_err meaningful on eop only
//   busy                             FSM not idle
//   pkt_cnt/drop_cnt                 delivered / discarded packet counters
// Build option: define X2C_ERR_DROP_EN to silently discard packets whose
// control word carries the error flag (data still drained at full rate).
module x2c_ctrl_pkt_sequencer
   import x2c_pkg::*;
#(
   parameter int DW   = 64,
   parameter int CW   = 32,
   parameter int LENW = 16
) (
   input  logic            clk,
   input  logic            srst,
   output logic            ctrl_rdreq,
   input  logic [CW-1:0]   ctrl_q,
   input  logic            ctrl_empty,
   output logic            data_rdreq,
   input  logic [DW-1:0]   data_q,
   input  logic            data_empty,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [DW-1:0]   out_data,
   output logic            out_sop,
   output logic            out_eop,
   output logic [DW/8-1:0] out_be,
   output logic            out_err,
   output logic            busy,
   output logic [31:0]     pkt_cnt,
   output logic [31:0]     drop_cnt
);

   localparam int BEW = DW / 8;
   localparam int PW  = DW + BEW + 3;

   state_t          state, state_nxt;
   logic [LENW-1:0] len_cw;
   logic [18:0]     beats_cw, remaining, rem_cur;
   logic [2:0]      len_lo, len_lo_cur;
   logic            err_q, err_cur, drop_cur;
   logic            sop_pend, sop_cur, eop_cur;
   logic [BEW-1:0]  be_cur;
   logic            active, len_zero, pop, credit_ok, done, pkt_end;
   logic [2:0]      outstanding;
   logic            vld_p1, drop_p1;
   logic [BEW+2:0]  meta_p1;
   logic [1:0]      occ;
   logic [PW-1:0]   buf_out;
   logic            unused_rsvd;

   assign unused_rsvd = ^ctrl_q[CW-1:ERR_BIT+1];

   // p0: pop decision. In CWAIT the control word is used straight from
   // ctrl_q so the first data pop overlaps the capture cycle.
   assign len_cw     = ctrl_q[LEN_MSB:LEN_LSB];
   assign beats_cw   = (19'(len_cw) + 19'd7) >> 3;
   assign rem_cur    = (state == CWAIT) ? beats_cw : remaining;
   assign len_lo_cur = (state == CWAIT) ? len_cw[2:0] : len_lo;
   assign err_cur    = (state == CWAIT) ? ctrl_q[ERR_BIT] : err_q;
   assign active     = (state == CWAIT) || (state == DATA);
   assign len_zero   = (state == CWAIT) && (len_cw == '0);
   assign sop_cur    = (state == CWAIT) || sop_pend;
   assign eop_cur    = (rem_cur == 19'd1);
   assign be_cur     = eop_cur ? BEW'(be_last(len_lo_cur)) : '1;
   assign pop        = out_valid && out_ready;

`ifdef X2C_ERR_DROP_EN
   assign drop_cur = err_cur;
`else
   assign drop_cur = 1'b0;
`endif

   // Buffered plus in-flight beats may not exceed two; a head leaving this
   // cycle frees its slot so the stream sustains one beat per cycle.
   assign outstanding = {1'b0, occ} + {2'b0, vld_p1};
   assign credit_ok   = drop_cur || (outstanding < (3'd2 + {2'b0, pop}));

   // One packet in flight: once nothing is left to pop or in flight, the
   // buffer holds only this packet's eop beat (or nothing when dropping).
   assign done    = (state == DATA) && (remaining == 19'd0) && !vld_p1 &&
                    ((occ == 2'd0) || ((occ == 2'd1) && pop));
   assign pkt_end = len_zero || done;
   assign busy    = (state != IDLE);

   always_comb begin
      state_nxt  = state;
      ctrl_rdreq = 1'b0;
      data_rdreq = 1'b0;
      if (!srst) begin
         ctrl_rdreq = !ctrl_empty && ((state == IDLE) || pkt_end);
         data_rdreq = active && !data_empty && (rem_cur != 19'd0) && credit_ok;
      end
      case (state)
         IDLE:    if (ctrl_rdreq) state_nxt = CWAIT;
         CWAIT:   if (len_zero) state_nxt = ctrl_rdreq ? CWAIT : IDLE;
                  else          state_nxt = DATA;
         DATA:    if (done) state_nxt = ctrl_rdreq ? CWAIT : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         state     <= IDLE;
         remaining <= '0;
         sop_pend  <= 1'b0;
         vld_p1    <= 1'b0;
         pkt_cnt   <= '0;
         drop_cnt  <= '0;
      end else begin
         state  <= state_nxt;
         vld_p1 <= data_rdreq;
         if ((state == CWAIT) || data_rdreq)
            remaining <= rem_cur - 19'(data_rdreq);
         if (data_rdreq)          sop_pend <= 1'b0;
         else if (state == CWAIT) sop_pend <= 1'b1;
         if (pop && out_eop) pkt_cnt <= pkt_cnt + 32'd1;
         if (len_zero || (data_rdreq && drop_cur && eop_cur))
            drop_cnt <= drop_cnt + 32'd1;
      end
   end

   // p1: data_q returns; framing computed at pop time travels with it.
   always_ff @(posedge clk) begin
      if (state == CWAIT) begin
         len_lo <= len_cw[2:0];
         err_q  <= ctrl_q[ERR_BIT];
      end
      if (data_rdreq) begin
         meta_p1 <= {err_cur && eop_cur, eop_cur, sop_cur, be_cur};
         drop_p1 <= drop_cur;
      end
   end

   // p2: buffer head drives out_*.
   x2c_skid_buf2 #(.W(PW)) u_buf (
      .clk       (clk),
      .srst      (srst),
      .in_valid  (vld_p1 && !drop_p1),
      .in_data   ({meta_p1, data_q}),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (buf_out),
      .occ       (occ)
   );

   assign {out_err, out_eop, out_sop, out_be, out_data} = buf_out;

endmodule

// File: tb/tb_x2c_ctrl_pkt_sequencer.sv
module tb_x2c_ctrl_pkt_sequencer;

`ifdef X2C_ERR_DROP_EN
   localparam bit DROP_ERR = 1'b1;
`else
   localparam bit DROP_ERR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        srst;
   logic        ctrl_rdreq, data_rdreq;
   logic [31:0] ctrl_q;
   logic [63:0] data_q;
   logic        ctrl_empty, data_empty;
   logic        out_valid, out_ready, out_sop, out_eop, out_err, busy;
   logic [63:0] out_data;
   logic [7:0]  out_be;
   logic [31:0] pkt_cnt, drop_cnt;

   always #5 clk = ~clk;

   x2c_ctrl_pkt_sequencer dut (
      .clk(clk), .srst(srst),
      .ctrl_rdreq(ctrl_rdreq), .ctrl_q(ctrl_q), .ctrl_empty(ctrl_empty),
      .data_rdreq(data_rdreq), .data_q(data_q), .data_empty(data_empty),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_sop(out_sop), .out_eop(out_eop), .out_be(out_be), .out_err(out_err),
      .busy(busy), .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
   );

   // FIFO contents, words waiting to trickle into the data FIFO, expected beats
   logic [31:0] ctrl_fifo[$];
   logic [63:0] data_fifo[$];
   logic [63:0] pending[$];
   logic [74:0] exp_beats[$];

   int n_assert = 0, n_fail = 0, cyc = 0;
   int exp_pkt = 0, exp_drop = 0;
   int n_pops = 0, n_acc = 0, n_vld = 0;
   int first_vld = -1, last_eop = -1, last_gap = -1, t_push = 0;
   int pidx = 0, rdy_mode = 0;
   bit hold_data = 0, chk_outst = 0;

   task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed='h%0h expected='h%0h", tag, obs, exp);
      end
   endtask

   task automatic refresh_flags();
      ctrl_empty = (ctrl_fifo.size() == 0);
      data_empty = (data_fifo.size() == 0) || hold_data;
   endtask

   task automatic set_ready(input int m);
      rdy_mode  = m;
      pidx      = 0;
      out_ready = 1'b1;
   endtask

   function automatic logic [7:0] exp_be(input int len, input int i, input int nb);
      if ((i == nb - 1) && ((len % 8) != 0)) return 8'hFF >> (8 - (len % 8));
      return 8'hFF;
   endfunction

   // Reference model: a packet of L bytes becomes ceil(L/8) beats unless it
   // is empty or (in drop builds) flagged bad.
   task automatic push_pkt(input int len, input bit err, input bit slow);
      int          nb;
      logic [63:0] w;
      logic        e_last, e_sop;
      bit          dropped;
      nb      = (len + 7) / 8;
      dropped = (len == 0) || (err && DROP_ERR);
      ctrl_fifo.push_back({15'($urandom), err, 16'(len)});
      for (int i = 0; i < nb; i++) begin
         w      = {$urandom, $urandom};
         e_last = (i == nb - 1);
         e_sop  = (i == 0);
         if (slow) pending.push_back(w);
         else      data_fifo.push_back(w);
         if (!dropped) exp_beats.push_back({err & e_last, e_last, e_sop, exp_be(len, i, nb), w});
      end
      if (dropped) exp_drop++;
      else         exp_pkt++;
      t_push = cyc + 1;
      refresh_flags();
   endtask

   task automatic tick();
      logic        c_rd, d_rd, acc;
      logic [74:0] obs;
      logic [74:0] expb;
      @(negedge clk);
      cyc++;
      c_rd = ctrl_rdreq;
      d_rd = data_rdreq;
      acc  = out_valid && out_ready;
      chk("ctrl_rdreq_while_empty", c_rd && ctrl_empty, 0);
      chk("data_rdreq_while_empty", d_rd && data_empty, 0);
      if (out_valid) n_vld++;
      if (out_valid && first_vld < 0) first_vld = cyc;
      if (d_rd) begin
         n_pops++;
         if (chk_outst) chk("beats_outstanding_le2", (n_pops - n_acc - int'(acc)) <= 2, 1);
      end
      if (acc) begin
         n_acc++;
         obs = {out_err, out_eop, out_sop, out_be, out_data};
         chk("beat_expected", exp_beats.size() > 0, 1);
         if (exp_beats.size() > 0) begin
            expb = exp_beats.pop_front();
            chk("beat", obs, expb);
         end
         if (out_sop && last_eop >= 0) last_gap = cyc - last_eop;
         if (out_eop) last_eop = cyc;
      end
      @(posedge clk);
      #1;
      if (c_rd && ctrl_fifo.size() > 0) ctrl_q = ctrl_fifo.pop_front();
      if (d_rd && data_fifo.size() > 0) data_q = data_fifo.pop_front();
      if (pending.size() > 0 && $urandom_range(0, 1) == 1) data_fifo.push_back(pending.pop_front());
      case (rdy_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = ((pidx % 3) == 2);
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
      pidx++;
      refresh_flags();
   endtask

   task automatic drain(input string tag, input int budget);
      bit ok = 0;
      for (int i = 0; i < budget && !ok; i++) begin
         tick();
         ok = (exp_beats.size() == 0) && !busy && (ctrl_fifo.size() == 0) &&
              (data_fifo.size() == 0) && (pending.size() == 0);
      end
      chk(tag, ok, 1);
   endtask

   task automatic clear_stats();
      n_pops = 0; n_acc = 0; n_vld = 0;
      first_vld = -1; last_eop = -1; last_gap = -1;
   endtask

   initial begin
      int p0;
      srst = 1'b1; ctrl_q = '0; data_q = '0; out_ready = 1'b0;
      refresh_flags();
      tick(); tick();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_flags", {out_sop, out_eop, out_err, out_be}, 0);
      chk("rst_busy", busy, 0);
      chk("rst_cnts", {pkt_cnt, drop_cnt}, 0);
      chk("rst_rdreqs", {ctrl_rdreq, data_rdreq}, 0);
      srst = 1'b0;
      tick();

      // 1: L=64, ready held high
      set_ready(0); clear_stats();
      push_pkt(64, 0, 0);
      drain("t1_drain", 100);
      chk("t1_beats", n_acc, 8);
      chk("t1_latency", first_vld - t_push, 3);
      chk("t1_pkt_cnt", pkt_cnt, exp_pkt);

      // 2: two L=13 packets back to back
      clear_stats();
      push_pkt(13, 0, 0);
      push_pkt(13, 0, 0);
      drain("t2_drain", 100);
      chk("t2_beats", n_acc, 4);
      chk("t2_eop_to_sop", last_gap, 3);

      // 3: L=64 with ready 1,0,0 repeating
      set_ready(1); clear_stats(); chk_outst = 1;
      out_ready = 1'b1;
      push_pkt(64, 0, 0);
      drain("t3_drain", 200);
      chk_outst = 0;
      chk("t3_beats", n_acc, 8);
      chk("t3_pops", n_pops, 8);

      // 4: empty packet then L=8
      set_ready(0); clear_stats();
      push_pkt(0, 0, 0);
      push_pkt(8, 0, 0);
      drain("t4_drain", 100);
      chk("t4_pops", n_pops, 1);
      chk("t4_beats", n_acc, 1);
      chk("t4_drop_cnt", drop_cnt, exp_drop);
      chk("t4_pkt_cnt", pkt_cnt, exp_pkt);

      // 5: bad-FCS packet of 16 bytes
      clear_stats();
      push_pkt(16, 1, 0);
      drain("t5_drain", 100);
      chk("t5_pops", n_pops, 2);
      chk("t5_vld_cycles", n_vld, DROP_ERR ? 0 : 2);
      chk("t5_drop_cnt", drop_cnt, exp_drop);
      chk("t5_pkt_cnt", pkt_cnt, exp_pkt);

      // 6: data FIFO dries up mid-packet, then reset
      clear_stats();
      push_pkt(64, 0, 0);
      repeat (4) tick();
      hold_data = 1; refresh_flags();
      p0 = n_pops;
      repeat (20) tick();
      chk("t6_pops_while_empty", n_pops - p0, 0);
      chk("t6_busy_stalled", busy, 1);
      srst = 1'b1;
      tick();
      ctrl_fifo.delete(); data_fifo.delete(); pending.delete(); exp_beats.delete();
      hold_data = 0; exp_pkt = 0; exp_drop = 0;
      srst = 1'b0;
      refresh_flags();
      #1;
      chk("t6_out_valid", out_valid, 0);
      chk("t6_out_data", out_data, 0);
      chk("t6_out_flags", {out_sop, out_eop, out_err, out_be}, 0);
      chk("t6_busy", busy, 0);
      chk("t6_cnts", {pkt_cnt, drop_cnt}, 0);
      chk("t6_rdreqs", {ctrl_rdreq, data_rdreq}, 0);
      tick();

      // 7: random packets, random ready, trickling data
      set_ready(2); clear_stats();
      for (int k = 0; k < 12; k++)
         push_pkt($urandom_range(0, 40), $urandom_range(0, 3) == 0, 1);
      drain("t7_drain", 3000);
      chk("t7_pkt_cnt", pkt_cnt, exp_pkt);
      chk("t7_drop_cnt", drop_cnt, exp_drop);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
